// File: rtl/board_eval.sv
// Material evaluator for successor boards in SDRAM: scores each board, writes the score back and tracks the best one.
// Define POSITIONAL_BONUS_EN to add a +/-10 bonus for pieces standing on the four centre squares.
module board_eval #(
  parameter int BOARD_WORDS = 64,
  parameter int MAX_BOARDS  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  localparam int SQW = (BOARD_WORDS > 1) ? $clog2(BOARD_WORDS) : 1;
  localparam int BW  = $clog2(MAX_BOARDS + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_SQ,
    WT_SQ,
    ACC,
    WR_SCORE,
    NEXT,
    FINISH
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0]        board_base;
  logic [31:0]        num_boards;
  logic [31:0]        score_base;
  logic               minimize;

  logic [BW-1:0]      nb;
  logic [BW-1:0]      b;
  logic [SQW-1:0]     sq;
  logic signed [7:0]  code;
  logic signed [31:0] score;
  logic signed [31:0] sq_value;

  logic [31:0]        best_index;
  logic signed [31:0] best_score;
  logic [31:0]        boards_done;

  logic               busy;
  logic               cpu_wr;
  logic               cpu_rd;
  logic               start;
  logic               last_sq;
  logic               better;
  logic [BW-1:0]      b_inc;
  logic [BW-1:0]      nb_clamped;
  logic [31:0]        rd_offset;
  logic [31:0]        wr_offset;
  logic               unused_readdata;

  function automatic logic [7:0] piece_mag(input logic signed [7:0] c);
    logic [7:0] m;
    m = c[7] ? (~c + 8'd1) : c;
    return m;
  endfunction

  // Magnitude 128 (code -128) and anything above 6 falls into the zero default.
  function automatic logic signed [31:0] piece_value(input logic signed [7:0] c);
    logic signed [31:0] v;
    case (piece_mag(c))
      8'd1:    v = 32'sd100;
      8'd2:    v = 32'sd320;
      8'd3:    v = 32'sd330;
      8'd4:    v = 32'sd500;
      8'd5:    v = 32'sd900;
      8'd6:    v = 32'sd20000;
      default: v = 32'sd0;
    endcase
    return c[7] ? -v : v;
  endfunction

`ifdef POSITIONAL_BONUS_EN
  function automatic logic signed [31:0] centre_bonus(input logic [SQW-1:0] s,
                                                      input logic signed [7:0] c);
    logic signed [31:0] v;
    logic               centre;
    logic               real_piece;
    centre     = (32'(s) == 32'd27) || (32'(s) == 32'd28) ||
                 (32'(s) == 32'd35) || (32'(s) == 32'd36);
    real_piece = (piece_mag(c) >= 8'd1) && (piece_mag(c) <= 8'd6);
    v = 32'sd0;
    if (centre && real_piece) begin
      v = c[7] ? -32'sd10 : 32'sd10;
    end
    return v;
  endfunction
`endif

  assign busy              = (state == RD_SQ) || (state == WT_SQ) || (state == ACC) ||
                             (state == WR_SCORE) || (state == NEXT);
  assign slave_waitrequest = busy;
  assign cpu_wr            = slave_write && !busy;
  assign cpu_rd            = slave_read && !busy;
  assign start             = (state == IDLE) && cpu_wr && (slave_address == 4'd0);

  assign nb_clamped = (num_boards > 32'(MAX_BOARDS)) ? BW'(MAX_BOARDS) : num_boards[BW-1:0];
  assign last_sq    = (sq == SQW'(BOARD_WORDS - 1));
  assign b_inc      = b + BW'(1);
  assign rd_offset  = (32'(b) * 32'(BOARD_WORDS) + 32'(sq)) << 2;
  assign wr_offset  = 32'(b) << 2;

  // Only the low byte of each SDRAM word carries a piece code.
  assign unused_readdata = ^master_readdata[31:8];

  always_comb begin
    sq_value = piece_value(code);
`ifdef POSITIONAL_BONUS_EN
    sq_value = sq_value + centre_bonus(sq, code);
`endif
  end

  // Board 0 always wins; afterwards only strict improvement replaces, so ties keep the lower index.
  always_comb begin
    better = 1'b0;
    if (b == '0) begin
      better = 1'b1;
    end else if (minimize) begin
      better = (score < best_score);
    end else begin
      better = (score > best_score);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next       = state;
    master_read      = 1'b0;
    master_write     = 1'b0;
    master_address   = 32'hFFFF_FFFF;
    master_writedata = 32'hFFFF_FFFF;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (nb_clamped == '0) ? FINISH : RD_SQ;
        end
      end
      RD_SQ: begin
        master_read    = 1'b1;
        master_address = board_base + rd_offset;
        if (!master_waitrequest) begin
          state_next = WT_SQ;
        end
      end
      WT_SQ: begin
        if (master_readdatavalid) begin
          state_next = ACC;
        end
      end
      ACC: begin
        state_next = last_sq ? WR_SCORE : RD_SQ;
      end
      WR_SCORE: begin
        master_write     = 1'b1;
        master_address   = score_base + wr_offset;
        master_writedata = score;
        if (!master_waitrequest) begin
          state_next = NEXT;
        end
      end
      NEXT: begin
        state_next = (b_inc == nb) ? FINISH : RD_SQ;
      end
      FINISH: begin
        if (cpu_rd && (slave_address == 4'd0)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    case (slave_address)
      4'd0:    slave_readdata = best_index;
      4'd5:    slave_readdata = best_score;
      4'd6:    slave_readdata = boards_done;
      default: slave_readdata = 32'd0;
    endcase
  end

  // Configuration is writable only while idle; busy-time accesses are stalled by waitrequest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board_base <= 32'd0;
      num_boards <= 32'd0;
      score_base <= 32'd0;
      minimize   <= 1'b0;
    end else if ((state == IDLE) && cpu_wr) begin
      case (slave_address)
        4'd1:    board_base <= slave_writedata;
        4'd2:    num_boards <= slave_writedata;
        4'd3:    score_base <= slave_writedata;
        4'd4:    minimize   <= slave_writedata[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nb          <= '0;
      b           <= '0;
      sq          <= '0;
      code        <= '0;
      score       <= 32'sd0;
      best_index  <= 32'hFFFF_FFFF;
      best_score  <= 32'sh8000_0000;
      boards_done <= 32'd0;
    end else begin
      if (start) begin
        nb          <= nb_clamped;
        b           <= '0;
        sq          <= '0;
        score       <= 32'sd0;
        best_index  <= 32'hFFFF_FFFF;
        best_score  <= 32'sh8000_0000;
        boards_done <= 32'd0;
      end
      if ((state == WT_SQ) && master_readdatavalid) begin
        code <= master_readdata[7:0];
      end
      if (state == ACC) begin
        score <= score + sq_value;
        if (!last_sq) begin
          sq <= sq + SQW'(1);
        end
      end
      if (state == NEXT) begin
        if (better) begin
          best_score <= score;
          best_index <= 32'(b);
        end
        boards_done <= boards_done + 32'd1;
        b           <= b_inc;
        score       <= 32'sd0;
        sq          <= '0;
      end
    end
  end

endmodule

// File: tb/tb_board_eval.sv
// Scoreboard bench for board_eval: a behavioural SDRAM feeds boards, a monitor checks score writes and register reads.
`timescale 1ns/1ps
module tb_board_eval;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        slave_waitrequest;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_write;
  logic [31:0] master_writedata;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  int          checks = 0;
  int          failures = 0;
  int          read_count = 0;
  bit          jitter = 1'b0;
  logic [7:0]  mem [int unsigned];
  xfer_t       exp_wr_q[$];
  xfer_t       exp_rd_q[$];

  localparam logic [31:0] BASE_A = 32'h0000_1000;
  localparam logic [31:0] BASE_K = 32'h0000_2000;
  localparam logic [31:0] BASE_C = 32'h0000_3000;
  localparam logic [31:0] BASE_E = 32'h0010_0000;

`ifdef POSITIONAL_BONUS_EN
  localparam int KNIGHT_SCORE = 330;
`else
  localparam int KNIGHT_SCORE = 320;
`endif

  always #5 clk = ~clk;

  board_eval dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_readdata       (slave_readdata),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata)
  );

  // SDRAM model: one read in flight, optional random stalls and response latency.
  initial begin : sdram
    bit          rd_pending;
    int          rd_delay;
    logic [31:0] rd_addr;
    rd_pending = 1'b0;
    rd_delay = 0;
    rd_addr = 32'd0;
    master_waitrequest = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata = 32'd0;
    forever begin
      @(negedge clk);
      master_readdatavalid = 1'b0;
      if (!rst_n) begin
        rd_pending = 1'b0;
        master_waitrequest = 1'b0;
      end else begin
        if (rd_pending) begin
          if (rd_delay == 0) begin
            master_readdatavalid = 1'b1;
            master_readdata = {24'hA5C3E1, mem.exists(rd_addr) ? mem[rd_addr] : 8'd0};
            rd_pending = 1'b0;
          end else begin
            rd_delay = rd_delay - 1;
          end
        end
        master_waitrequest = jitter ? ($urandom_range(0, 2) == 0) : 1'b0;
        if (master_read && !master_waitrequest) begin
          rd_pending = 1'b1;
          rd_delay = jitter ? int'($urandom_range(0, 5)) : 0;
          rd_addr = master_address;
          read_count = read_count + 1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a score write or a register read is accepted.
  initial begin : monitor
    xfer_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && master_write && !master_waitrequest) begin
        checks++;
        if (exp_wr_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL score_write unexpected: got addr=%h data=%0d, required none",
                   master_address, $signed(master_writedata));
        end else begin
          e = exp_wr_q.pop_front();
          if (master_address !== e.addr || master_writedata !== e.data) begin
            failures++;
            $display("[TB] FAIL score_write: got addr=%h data=%0d, required addr=%h data=%0d",
                     master_address, $signed(master_writedata), e.addr, $signed(e.data));
          end
        end
      end
      if (rst_n && slave_read && !slave_waitrequest) begin
        checks++;
        if (exp_rd_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL reg_read unexpected: addr=%0d got %h", slave_address, slave_readdata);
        end else begin
          e = exp_rd_q.pop_front();
          if (32'(slave_address) !== e.addr || slave_readdata !== e.data) begin
            failures++;
            $display("[TB] FAIL reg_read addr=%0d: got %h, required %h (addr %0d)",
                     slave_address, slave_readdata, e.data, e.addr);
          end
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] a, input logic [31:0] d);
    int budget;
    bit ok;
    budget = 0;
    ok = 1'b0;
    @(negedge clk);
    slave_address = a;
    slave_writedata = d;
    slave_write = 1'b1;
    while (!ok && budget < 20000) begin
      #1;
      ok = !slave_waitrequest;
      @(negedge clk);
      budget++;
    end
    slave_write = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL reg_write timeout: addr=%0d", a);
    end
  endtask

  task automatic read_reg(input logic [3:0] a, input logic [31:0] exp);
    int budget;
    bit ok;
    budget = 0;
    ok = 1'b0;
    exp_rd_q.push_back({32'(a), exp});
    @(negedge clk);
    slave_address = a;
    slave_read = 1'b1;
    while (!ok && budget < 20000) begin
      #1;
      ok = !slave_waitrequest;
      @(negedge clk);
      budget++;
    end
    slave_read = 1'b0;
    if (!ok) begin
      void'(exp_rd_q.pop_back());
      checks++;
      failures++;
      $display("[TB] FAIL reg_read timeout: addr=%0d", a);
    end
  endtask

  function automatic logic [7:0] back_rank(input int x);
    case (x)
      0, 7:    return 8'd4;
      1, 6:    return 8'd2;
      2, 5:    return 8'd3;
      3:       return 8'd5;
      default: return 8'd6;
    endcase
  endfunction

  task automatic put_code(input logic [31:0] base, input int idx, input int sq, input logic [7:0] c);
    mem[base + 32'(4 * (64 * idx + sq))] = c;
  endtask

  task automatic load_start(input logic [31:0] base, input int idx, input int drop_sq);
    logic [7:0] c;
    for (int sq = 0; sq < 64; sq++) begin
      case (sq / 8)
        0:       c = back_rank(sq % 8);
        1:       c = 8'd1;
        6:       c = 8'hFF;
        7:       c = 8'd0 - back_rank(sq % 8);
        default: c = 8'd0;
      endcase
      if (sq == drop_sq) c = 8'd0;
      put_code(base, idx, sq, c);
    end
  endtask

  task automatic configure(input logic [31:0] bb, input logic [31:0] n,
                           input logic [31:0] sb, input logic mn);
    apply_stimulus(4'd1, bb);
    apply_stimulus(4'd2, n);
    apply_stimulus(4'd3, sb);
    apply_stimulus(4'd4, {31'd0, mn});
  endtask

  task automatic expect_score(input logic [31:0] sb, input int i, input int s);
    exp_wr_q.push_back({sb + 32'(4 * i), 32'(s)});
  endtask

  task automatic run_and_check(input string name, input logic [31:0] exp_best,
                               input logic [31:0] exp_score, input logic [31:0] exp_done,
                               input int exp_reads);
    int r0;
    r0 = read_count;
    apply_stimulus(4'd0, 32'd0);
    read_reg(4'd0, exp_best);
    read_reg(4'd5, exp_score);
    read_reg(4'd6, exp_done);
    check_output({name, "_reads"}, 32'(read_count - r0), 32'(exp_reads));
    check_output({name, "_pending_writes"}, 32'(exp_wr_q.size()), 32'd0);
  endtask

  initial begin : stimulus
    int rc;
    int budget;
    rst_n = 1'b0;
    slave_address = 4'd0;
    slave_read = 1'b0;
    slave_write = 1'b0;
    slave_writedata = 32'd0;

    load_start(BASE_A, 0, -1);
    load_start(BASE_A, 1, 59);
    load_start(BASE_A, 2, -1);
    put_code(BASE_K, 0, 27, 8'd2);
    put_code(BASE_C, 0, 4, 8'hFA);
    put_code(BASE_C, 0, 12, 8'd1);
    put_code(BASE_C, 1, 0, 8'd7);
    put_code(BASE_C, 1, 1, 8'hF7);
    put_code(BASE_C, 1, 2, 8'h80);
    put_code(BASE_C, 1, 20, 8'd3);

    repeat (3) @(negedge clk);
    #1;
    check_output("reset_master_read", {31'd0, master_read}, 32'd0);
    check_output("reset_master_write", {31'd0, master_write}, 32'd0);
    check_output("reset_master_address", master_address, 32'hFFFF_FFFF);
    check_output("reset_master_writedata", master_writedata, 32'hFFFF_FFFF);
    check_output("reset_waitrequest", {31'd0, slave_waitrequest}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    read_reg(4'd0, 32'hFFFF_FFFF);
    read_reg(4'd5, 32'h8000_0000);
    read_reg(4'd6, 32'd0);
    read_reg(4'd7, 32'd0);

    $display("[TB] start position, one board");
    configure(BASE_A, 32'd1, 32'h8000, 1'b0);
    expect_score(32'h8000, 0, 0);
    run_and_check("start1", 32'd0, 32'd0, 32'd1, 64);

    $display("[TB] three boards, maximize");
    configure(BASE_A, 32'd3, 32'h9000, 1'b0);
    expect_score(32'h9000, 0, 0);
    expect_score(32'h9000, 1, 900);
    expect_score(32'h9000, 2, 0);
    run_and_check("max3", 32'd1, 32'd900, 32'd3, 192);

    $display("[TB] three boards, minimize");
    configure(BASE_A, 32'd3, 32'h9000, 1'b1);
    expect_score(32'h9000, 0, 0);
    expect_score(32'h9000, 1, 900);
    expect_score(32'h9000, 2, 0);
    run_and_check("min3", 32'd0, 32'd0, 32'd3, 192);

    $display("[TB] negative and out-of-range codes");
    configure(BASE_C, 32'd2, 32'hA000, 1'b0);
    expect_score(32'hA000, 0, -19900);
    expect_score(32'hA000, 1, 330);
    run_and_check("oddmax", 32'd1, 32'd330, 32'd2, 128);
    configure(BASE_C, 32'd2, 32'hA000, 1'b1);
    expect_score(32'hA000, 0, -19900);
    expect_score(32'hA000, 1, 330);
    run_and_check("oddmin", 32'd0, 32'(-19900), 32'd2, 128);

    $display("[TB] zero boards");
    configure(BASE_A, 32'd0, 32'hB000, 1'b0);
    run_and_check("zero", 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);

    $display("[TB] clamped board count");
    configure(BASE_E, 32'd100, 32'hC000, 1'b0);
    for (int i = 0; i < 64; i++) expect_score(32'hC000, i, 0);
    run_and_check("clamp", 32'd0, 32'd0, 32'd64, 4096);

    $display("[TB] random SDRAM latency");
    jitter = 1'b1;
    configure(BASE_A, 32'd3, 32'h9000, 1'b0);
    expect_score(32'h9000, 0, 0);
    expect_score(32'h9000, 1, 900);
    expect_score(32'h9000, 2, 0);
    run_and_check("jmax3", 32'd1, 32'd900, 32'd3, 192);
    configure(BASE_A, 32'd3, 32'h9000, 1'b1);
    expect_score(32'h9000, 0, 0);
    expect_score(32'h9000, 1, 900);
    expect_score(32'h9000, 2, 0);
    run_and_check("jmin3", 32'd0, 32'd0, 32'd3, 192);
    jitter = 1'b0;

    $display("[TB] lone knight on d4");
    configure(BASE_K, 32'd1, 32'hD000, 1'b0);
    expect_score(32'hD000, 0, KNIGHT_SCORE);
    run_and_check("knight", 32'd0, 32'(KNIGHT_SCORE), 32'd1, 64);

    $display("[TB] reset during square read");
    configure(BASE_A, 32'd3, 32'hE000, 1'b0);
    apply_stimulus(4'd0, 32'd0);
    budget = 0;
    #1;
    while (!master_read && budget < 1000) begin
      @(negedge clk);
      #1;
      budget++;
    end
    check_output("abort_reached_rd_sq", {31'd0, master_read}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("abort_master_read", {31'd0, master_read}, 32'd0);
    check_output("abort_master_address", master_address, 32'hFFFF_FFFF);
    check_output("abort_waitrequest", {31'd0, slave_waitrequest}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rc = read_count;
    repeat (10) @(negedge clk);
    #1;
    check_output("abort_no_reads", 32'(read_count - rc), 32'd0);
    check_output("abort_no_write", {31'd0, master_write}, 32'd0);
    read_reg(4'd0, 32'hFFFF_FFFF);
    read_reg(4'd6, 32'd0);
    check_output("abort_pending_reads", 32'(exp_rd_q.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
